sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 61 ++++++
 tb/tb_sipo_deser.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with a valid/ready output register.
// The completed word is captured on the edge that samples its last bit.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     din,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         dout,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             last;

  always_comb begin
    sr_next = sr;
    if (MSB_FIRST != 0) sr_next = {sr[WIDTH-2:0], din};
    else                sr_next = {din, sr[WIDTH-1:1]};
  end

  // bit_cnt wraps explicitly so non-power-of-two widths still frame correctly
  assign last = en && (bit_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      dout      <= '0;
      bit_cnt   <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (clr) begin
      sr       <= '0;
      bit_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (en) begin
        sr      <= sr_next;
        bit_cnt <= last ? '0 : bit_cnt + CW'(1);
      end
      if (last) begin
        dout      <= sr_next;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) overflow <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an MSB-first and an LSB-first instance share
// stimulus; expected words are queued per frame and popped at completion.
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst, clr, en, din, out_ready;
  logic [7:0] dout_m, dout_l;
  logic       valid_m, valid_l, ovf_m, ovf_l;
  logic [2:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_m[$];
  logic [7:0] q_l[$];

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .din(din), .out_ready(out_ready),
    .dout(dout_m), .out_valid(valid_m), .bit_cnt(cnt_m), .overflow(ovf_m)
  );

  sipo_deser #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .din(din), .out_ready(out_ready),
    .dout(dout_l), .out_valid(valid_l), .bit_cnt(cnt_l), .overflow(ovf_l)
  );

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    en  = 1'b1;
    din = b;
    step();
  endtask

  // Bits go out in transmission order w[7]..w[0]; the LSB-first instance
  // therefore sees the bit-reversed word.
  task automatic push_word(input logic [7:0] w);
    q_m.push_back(w);
    q_l.push_back(rev8(w));
  endtask

  task automatic send_word(input logic [7:0] w);
    push_word(w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic expect_out(input string tag);
    logic [7:0] em, el;
    chk({tag, "_valid_m"}, valid_m, 1);
    chk({tag, "_valid_l"}, valid_l, 1);
    if (q_m.size() == 0 || q_l.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue: observed empty expected word", tag);
    end else begin
      em = q_m.pop_front();
      el = q_l.pop_front();
      chk({tag, "_dout_m"}, dout_m, em);
      chk({tag, "_dout_l"}, dout_l, el);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dout"},  {dout_m, dout_l}, 0);
    chk({tag, "_valid"}, {valid_m, valid_l}, 0);
    chk({tag, "_cnt"},   {cnt_m, cnt_l}, 0);
    chk({tag, "_ovf"},   {ovf_m, ovf_l}, 0);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1; clr = 1'b1; en = 1'b1; din = 1'b1; out_ready = 1'b1;
    #1;
    step(); step();
    chk_zero("reset");
    rst = 1'b0; clr = 1'b0; en = 1'b0; din = 1'b0; out_ready = 1'b0;
    step();

    // 1,0,1,1,0,0,1,0 -> B2 MSB-first, 4D LSB-first
    send_word(8'hB2);
    chk("b2_lsb_literal", dout_l, 8'h4D);
    expect_out("b2");
    chk("b2_cnt", cnt_m, 0);
    chk("b2_ovf", ovf_m, 0);
    en = 1'b0;

    out_ready = 1'b1;
    step();
    chk("hs_valid", valid_m, 0);
    chk("hs_dout_hold", dout_m, 8'hB2);
    step();
    chk("idle_ready_valid", valid_m, 0);
    chk("idle_ready_ovf", ovf_m, 0);
    out_ready = 1'b0;

    // back-to-back frames, nothing consumed
    send_word(8'hB2);
    expect_out("bb1");
    chk("bb1_ovf", ovf_m, 0);
    send_word(8'hFF);
    expect_out("bb2");
    chk("bb2_ovf_m", ovf_m, 1);
    chk("bb2_ovf_l", ovf_l, 1);
    chk("bb2_cnt", cnt_m, 0);
    en = 1'b0;
    step();
    chk("ovf_sticky", ovf_m, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", ovf_m, 0);
    chk("clr_dout", dout_m, 8'hFF);
    chk("clr_valid", valid_m, 1);

    // consume, then complete a frame on the same edge as out_ready
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    send_word(8'h3C);
    expect_out("w3c");
    en = 1'b0;
    w = 8'hA5;
    push_word(w);
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    out_ready = 1'b1;
    send_bit(w[0]);
    out_ready = 1'b0;
    en = 1'b0;
    expect_out("same_edge");
    chk("same_edge_ovf", ovf_m, 0);

    // en toggled 1,0,1,0 through the first half of a frame
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    w = 8'h5A;
    push_word(w);
    for (int i = 7; i >= 0; i--) begin
      send_bit(w[i]);
      if (i >= 4) begin
        en = 1'b0;
        din = ~din;
        step();
        chk($sformatf("gap_cnt_%0d", 8 - i), cnt_m, (8 - i) % 8);
      end
    end
    en = 1'b0;
    expect_out("gap");

    // clr on the completion edge discards the frame
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    w = 8'h77;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    clr = 1'b1;
    send_bit(w[0]);
    clr = 1'b0;
    en = 1'b0;
    chk("clr_last_valid", valid_m, 0);
    chk("clr_last_cnt", cnt_m, 0);
    chk("clr_last_dout", dout_m, 8'h5A);
    send_word(8'h81);
    expect_out("after_clr");
    en = 1'b0;

    // rst after 5 bits of a frame
    w = 8'hC3;
    for (int i = 7; i >= 3; i--) send_bit(w[i]);
    chk("pre_rst_cnt", cnt_m, 5);
    rst = 1'b1;
    send_bit(1'b1);
    rst = 1'b0;
    en = 1'b0;
    chk_zero("mid_rst");
    send_word(8'h96);
    expect_out("post_rst");
    en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of stimulus expected completion");
    $fatal(1, "timeout");
  end

endmodule
